// File: rtl/mips_pkg.sv
// Shared widths, reset constants and the fetch-queue entry type for the MIPS front end.
package mips_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory port, redirect input and decode valid/ready channel.
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
  parameter int unsigned INST_W = mips_pkg::INST_W
);

  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_inst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );

endinterface

// File: rtl/ifu_fetch_queue.sv
// Two-entry FIFO between the instruction memory response and decode; head is always visible.
module ifu_fetch_queue
  import mips_pkg::*;
#(
  parameter type entry_t = ifq_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  entry_t     i_data,
  input  logic       i_pop,
  input  logic       i_flush,
  output entry_t     o_head,
  output logic [1:0] o_count
);

  entry_t     r_mem [2];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, credit-based issue, one-deep in-flight tracker, 2-entry queue.
// Define IFU_PERF_CNT_EN to add the perf_fetched/perf_stall/perf_redirect counters.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = mips_pkg::ADDR_W,
  parameter int unsigned       INST_W   = mips_pkg::INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_fetch_unit_if.master  ifu_bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_stall,
  output logic [31:0]               perf_redirect
`endif
);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } slot_t;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_inflight;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [1:0]        w_count;
  logic [2:0]        w_credits;
  slot_t             w_resp;
  slot_t             w_head;

  assign w_redirect    = ifu_bus.redirect_valid;
  assign w_redirect_pc = ifu_bus.redirect_pc & ~ADDR_W'(3);
  assign w_pop         = ifu_bus.out_valid && ifu_bus.out_ready;
  assign w_push        = r_inflight && !w_redirect;

  // Entries held plus the one possibly in flight, less the slot freed this edge,
  // must leave room for the response to a new request: the queue can never overflow.
  assign w_credits = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = !w_redirect && (w_credits < 3'd2);

  assign w_resp = '{inst: ifu_bus.imem_inst, pc: r_req_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_fetch_pc <= w_redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_issue) begin
        r_req_pc <= r_fetch_pc;
      end
      r_inflight <= w_issue;
    end
  end

  ifu_fetch_queue #(
    .entry_t (slot_t)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_resp),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign ifu_bus.imem_addr = r_fetch_pc;
  assign ifu_bus.out_valid = (w_count != 2'd0);
  assign ifu_bus.out_inst  = w_head.inst;
  assign ifu_bus.out_pc    = w_head.pc;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched  <= '0;
      r_perf_stall    <= '0;
      r_perf_redirect <= '0;
    end else begin
      if (w_pop) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (ifu_bus.out_valid && !ifu_bus.out_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_redirect) begin
        r_perf_redirect <= r_perf_redirect + 32'd1;
      end
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_stall    = r_perf_stall;
  assign perf_redirect = r_perf_redirect;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios then random ready/redirect traffic.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instruction_fetch_unit_if ifu_bus ();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_redirect;
`endif

  instruction_fetch_unit #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ifu_bus (ifu_bus)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall),
    .perf_redirect (perf_redirect)
`endif
  );

  always #5 clk = ~clk;

  // Memory content is a fixed scramble of the word index.
  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    return (idx * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) ifu_bus.imem_inst <= imem_word(ifu_bus.imem_addr);

  // Reference: the next pc decode should receive, and edges since reset/redirect.
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_pc;
  int unsigned since;
  logic        exp_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc    = RESET_PC;
    since     = 0;
    exp_valid = 1'b0;
  endtask

  // Called at a negedge: check current outputs, drive inputs, advance one edge.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    chk("out_valid", {31'b0, ifu_bus.out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("out_pc", ifu_bus.out_pc, exp_pc);
      chk("out_inst", ifu_bus.out_inst, imem_word(exp_pc));
    end
    ifu_bus.out_ready      = rdy;
    ifu_bus.redirect_valid = rv;
    ifu_bus.redirect_pc    = rpc;
    @(posedge clk);
    if (exp_valid && rdy) exp_pc += 32'd4;
    if (rv) begin
      exp_pc = rpc & 32'hFFFF_FFFC;
      since  = 0;
    end else if (since < 2) begin
      since++;
    end
    exp_valid = (since >= 2);
    @(negedge clk);
    if (rv) chk("imem_addr_after_redirect", ifu_bus.imem_addr, rpc & 32'hFFFF_FFFC);
  endtask

  // Asynchronous reset between edges; effect must be visible before any clock edge.
  task automatic reset_and_check();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", {31'b0, ifu_bus.out_valid}, 32'd0);
    chk("reset_imem_addr", ifu_bus.imem_addr, RESET_PC);
    chk("reset_out_pc", ifu_bus.out_pc, 32'd0);
    chk("reset_out_inst", ifu_bus.out_inst, 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("reset_perf_fetched", perf_fetched, 32'd0);
    chk("reset_perf_stall", perf_stall, 32'd0);
    chk("reset_perf_redirect", perf_redirect, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    ifu_bus.out_ready      = 1'b1;
    ifu_bus.redirect_valid = 1'b0;
    ifu_bus.redirect_pc    = '0;
    model_reset();
    @(negedge clk);
    reset_and_check();

    // Streaming from reset with decode always ready
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Back-pressure then release
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

    // Redirect while the queue is full
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

    // Redirect coinciding with a pop
    step(1'b1, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

    // Misaligned target near the top of the address space, then wrap
    step(1'b1, 1'b1, 32'hFFFF_FFFA);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Redirect held over consecutive cycles
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b1, 32'h0000_0300);
    step(1'b1, 1'b1, 32'h0000_0404);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

    // Random ready/redirect traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
    end

    // Reset in the middle of a stall
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    reset_and_check();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
